timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Register-mapped control front end for the 8-bit prescaled up/down timer.
- Accepts APB-style CPU accesses and drives the timer's load/up_dw/en/cks/data inputs.
- Consumes the timer's tcnt/ovf/udf outputs, latching ovf/udf into sticky W1C status flags and producing a level interrupt.
- Sits between the peripheral bus and the timer instance.

Parameters:
- WAIT_STATES, 0, extra ACCESS-phase cycles before pready asserts (0..7).
- ADDR_W, 4, width of paddr; only word indices 0..3 are valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  register index
- pwdata  in  8  write data
- prdata  out  8  read data, valid when pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid with pready
- tmr_en  out  1  timer enable (TCR.EN)
- tmr_up_dw  out  1  0=count up, 1=count down (TCR.DIR)
- tmr_cks  out  2  prescale select (TCR.CKS)
- tmr_load  out  1  single-cycle load strobe
- tmr_data  out  8  load value (TDR)
- tmr_tcnt  in  8  live counter value
- tmr_ovf  in  1  overflow pulse from timer
- tmr_udf  in  1  underflow pulse from timer
- irq  out  1  registered interrupt

Behaviour:
Reset:
- All registers 0: TDR, TCR, TSR, irq, tmr_load, prdata, pready, pslverr.
- Bus FSM returns to IDLE.
- Asserting reset mid-transfer aborts the transfer; no register update.

Register map (paddr):
- 0 TDR: RW, 8 bits; drives tmr_data continuously.
- 1 TCR: RW.
  - bit0 EN, bit1 DIR, bits3:2 CKS.
  - bit4 OVIE, bit5 UDIE.
  - bit6 LD: write-1 strobe, reads 0.
  - bit7 ARE (only with the optional feature; otherwise reads 0, write ignored).
- 2 TSR: bit0 OVF, bit1 UDF; W1C; bits7:2 read 0.
- 3 TCNT: read-only mirror of tmr_tcnt, sampled in the completing cycle.

Bus FSM (IDLE, SETUP, ACCESS):
- IDLE→SETUP on psel & !penable.
- SETUP→ACCESS when penable=1.
- In ACCESS, an internal wait counter counts WAIT_STATES cycles. pready=1 on the cycle the counter equals WAIT_STATES; WAIT_STATES=0 gives one ACCESS cycle.
- ACCESS→IDLE when pready=1, or →SETUP if psel stays high for a back-to-back transfer.
- Register writes and W1C take effect on the pready=1 cycle only.
- pslverr=1 together with pready for paddr>3, or for a write to TCNT; no state change on an error.
- pready, pslverr and prdata are 0 outside the completing cycle.

Load strobe:
- A TCR write with LD=1 pulses tmr_load for exactly one cycle, the cycle after completion.
- The EN/DIR/CKS fields written in the same access are already visible on tmr_* in that cycle.
- A TDR write does not load by itself.

Status:
- tmr_ovf=1 sets OVF; tmr_udf=1 sets UDF.
- If a hardware set and a W1C of the same bit occur in the same cycle, set wins.
- A W1C of 0 leaves the bit unchanged.

Interrupt:
- irq is registered: irq <= (OVF&OVIE)|(UDF&UDIE).
- irq rises one cycle after the flag sets, and falls one cycle after the flag clears or the enable bit is cleared.

Optional Feature:
- Macro TIMER_CTRL_AUTORELOAD_EN.
- Defined:
  - TCR.ARE is implemented.
  - When ARE=1 and tmr_ovf or tmr_udf pulses, tmr_load pulses the following cycle with tmr_data=TDR, giving periodic mode.
  - A CPU LD strobe and an auto-reload in the same cycle merge into one tmr_load pulse.
- Undefined:
  - TCR bit7 reads 0 and is not stored.
  - The timer free-runs through wrap-around.

Decomposition:
- Package timer_pkg holds:
  - register index constants TDR_IDX/TCR_IDX/TSR_IDX/TCNT_IDX;
  - TCR bit-position constants;
  - cks enum (DIV2=0, DIV4=1, DIV8=2, DIV16=3);
  - bus FSM state enum.
- One sub-module is natural: timer_apb_fsm, containing the SETUP/ACCESS FSM, wait counter and pready/pslverr generation, with outputs wr_stb/rd_stb/addr.
- Register file and status logic stay in timer_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS → all outputs 0; a following read of TCR returns 0x00, pslverr=0.
- Write TDR=0xA5, then TCR=0x41 (LD|EN) → tmr_data=0xA5; tmr_en=1 in the cycle tmr_load pulses for 1 cycle; read TCR → 0x01.
- Pulse tmr_ovf with OVIE=1 → TSR reads 0x01, irq=1 one cycle later; W1C 0x01 in the same cycle as a second tmr_ovf → OVF stays 1.
- WAIT_STATES=3: read TCNT with tmr_tcnt=0x3C → pready on the 4th ACCESS cycle, prdata=0x3C; paddr=5 → pslverr=1, no register changes.
- Write to TCNT (paddr=3) → pslverr=1; a back-to-back write of TDR with psel held high completes correctly.
- With TIMER_CTRL_AUTORELOAD_EN, ARE=1, DIR=1, TDR=0x10: tmr_udf pulse → tmr_load pulses the next cycle with tmr_data=0x10, TSR.UDF=1. Without the macro → no tmr_load pulse, and TCR bit7 reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer control front end.
package timer_pkg;

  localparam int unsigned REG_IDX_W  = 2;
  localparam int unsigned WAIT_CNT_W = 3;

  localparam logic [REG_IDX_W-1:0] TDR_IDX  = 2'd0;
  localparam logic [REG_IDX_W-1:0] TCR_IDX  = 2'd1;
  localparam logic [REG_IDX_W-1:0] TSR_IDX  = 2'd2;
  localparam logic [REG_IDX_W-1:0] TCNT_IDX = 2'd3;

  localparam int unsigned TCR_EN   = 0;
  localparam int unsigned TCR_DIR  = 1;
  localparam int unsigned TCR_CKS  = 2;
  localparam int unsigned TCR_OVIE = 4;
  localparam int unsigned TCR_UDIE = 5;
  localparam int unsigned TCR_LD   = 6;
  localparam int unsigned TCR_ARE  = 7;

  localparam int unsigned TSR_OVF = 0;
  localparam int unsigned TSR_UDF = 1;

  typedef enum logic [1:0] {
    DIV2  = 2'd0,
    DIV4  = 2'd1,
    DIV8  = 2'd2,
    DIV16 = 2'd3
  } cks_e;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_ACCESS = 2'd2
  } bus_state_e;

endpackage

// File: rtl/timer_apb_fsm.sv
// APB slave sequencer: tracks SETUP/ACCESS, inserts wait states and flags
// the completing cycle. rd_stb_c announces a read completing next cycle.
module timer_apb_fsm
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              pready,
  output logic              pslverr,
  output logic              wr_stb,
  output logic              rd_stb_c,
  output logic [1:0]        addr
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);

  bus_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  done_d, err_d, wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      wr_stb  <= 1'b0;
      addr    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pready  <= done_d;
      pslverr <= err_d;
      wr_stb  <= wr_d;
      addr    <= paddr[1:0];
    end
  end

  // Responses are registered, so completion is decided one cycle ahead.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_d     = 1'b0;
    rd_stb_c = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        cnt_d = '0;
        if (psel && !penable) state_d = BUS_SETUP;
      end
      BUS_SETUP: begin
        cnt_d = '0;
        if (!psel)        state_d = BUS_IDLE;
        else if (penable) state_d = BUS_ACCESS;
      end
      BUS_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = psel ? BUS_SETUP : BUS_IDLE;
        end else begin
          cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
      end
      default: state_d = BUS_IDLE;
    endcase
    done_d   = (state_d == BUS_ACCESS) && (cnt_d == WAIT_LAST);
    err_d    = done_d && ((paddr > ADDR_W'(3)) || (pwrite && (paddr[1:0] == TCNT_IDX)));
    wr_d     = done_d && pwrite && !err_d;
    rd_stb_c = done_d && !pwrite && !err_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Register front end for the 8-bit prescaled up/down timer.
// Define TIMER_CTRL_AUTORELOAD_EN to implement TCR.ARE (periodic reload).
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_en,
  output logic              tmr_up_dw,
  output logic [1:0]        tmr_cks,
  output logic              tmr_load,
  output logic [7:0]        tmr_data,
  input  logic [7:0]        tmr_tcnt,
  input  logic              tmr_ovf,
  input  logic              tmr_udf,
  output logic              irq
);

`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam logic [7:0] TCR_WMASK = 8'hBF;
`else
  localparam logic [7:0] TCR_WMASK = 8'h3F;
`endif

  logic       wr_stb, rd_stb_c;
  logic [1:0] addr;
  logic [7:0] tdr_q, tcr_q;
  logic       ovf_q, udf_q;
  logic       tcr_wr_c, tsr_wr_c, reload_c;
  logic [7:0] rd_mux_c;
  cks_e       cks;

  timer_apb_fsm #(
    .WAIT_STATES (WAIT_STATES),
    .ADDR_W      (ADDR_W)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pready   (pready),
    .pslverr  (pslverr),
    .wr_stb   (wr_stb),
    .rd_stb_c (rd_stb_c),
    .addr     (addr)
  );

  assign tcr_wr_c = wr_stb && (addr == TCR_IDX);
  assign tsr_wr_c = wr_stb && (addr == TSR_IDX);

`ifdef TIMER_CTRL_AUTORELOAD_EN
  assign reload_c = tcr_q[TCR_ARE] && (tmr_ovf || tmr_udf);
`else
  assign reload_c = 1'b0;
`endif

  // Control/data registers; LD is a strobe and is never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr_q    <= '0;
      tcr_q    <= '0;
      tmr_load <= 1'b0;
    end else begin
      if (wr_stb && (addr == TDR_IDX)) tdr_q <= pwdata;
      if (tcr_wr_c) tcr_q <= pwdata & TCR_WMASK;
      tmr_load <= (tcr_wr_c && pwdata[TCR_LD]) || reload_c;
    end
  end

  // Sticky status: a hardware set in the same cycle as W1C wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      irq   <= 1'b0;
    end else begin
      ovf_q <= tmr_ovf || (ovf_q && !(tsr_wr_c && pwdata[TSR_OVF]));
      udf_q <= tmr_udf || (udf_q && !(tsr_wr_c && pwdata[TSR_UDF]));
      irq   <= (ovf_q && tcr_q[TCR_OVIE]) || (udf_q && tcr_q[TCR_UDIE]);
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (paddr[1:0])
      TDR_IDX: rd_mux_c = tdr_q;
      TCR_IDX: rd_mux_c = tcr_q;
      TSR_IDX: rd_mux_c = {6'd0, udf_q, ovf_q};
      default: rd_mux_c = tmr_tcnt;
    endcase
  end

  // Read data is loaded into the completing cycle and zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prdata <= '0;
    else        prdata <= rd_stb_c ? rd_mux_c : 8'h00;
  end

  assign cks       = cks_e'(tcr_q[TCR_CKS +: 2]);
  assign tmr_cks   = cks;
  assign tmr_en    = tcr_q[TCR_EN];
  assign tmr_up_dw = tcr_q[TCR_DIR];
  assign tmr_data  = tdr_q;

endmodule
